// File: rtl/acondicionador_de_sensores.sv
// acondicionador_de_sensores: sync, debounce and optional latch of the four alarm sensor flags
// Defining ALARMA_RETENCION_EN holds Temperatura/SobreCarga/Humo until ack.
module acondicionador_de_sensores #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic temp_raw,
  input  logic manual_raw,
  input  logic sobrecarga_raw,
  input  logic humo_raw,
  input  logic ack,
  output logic Temperatura,
  output logic Manual,
  output logic SobreCarga,
  output logic Humo,
  output logic evento
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);
  logic [3:0] s1_q, s2_q, filt_q, filt_d, out_q, out_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic evento_q, evento_d;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      filt_d[i] = filt_q[i] ^ (s2_q[i] != filt_q[i] && cnt_q[i] == LAST);
      cnt_d[i]  = (s2_q[i] != filt_q[i] && cnt_q[i] != LAST) ? cnt_q[i] + 1'b1 : '0;
    end
  end
`ifdef ALARMA_RETENCION_EN
  typedef enum logic [1:0] {IDLE, ACTIVO, RETENIDO} st_t;
  st_t [2:0] st_q, st_d;
  logic [2:0] hf, hout;
  assign hf = {filt_d[3], filt_d[1], filt_d[0]};
  // filt wins over ack, so a re-asserted fault returns straight to ACTIVO
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      st_d[j] = hf[j] ? ACTIVO :
                st_q[j] == ACTIVO ? RETENIDO :
                (st_q[j] == RETENIDO && !ack) ? RETENIDO : IDLE;
      hout[j] = st_d[j] != IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) st_q <= {IDLE, IDLE, IDLE};
    else       st_q <= st_d;
  assign out_d = {hout[2], filt_d[2], hout[1], hout[0]};
`else
  logic unused_ack;
  assign unused_ack = ack;
  assign out_d = filt_d;
`endif
  assign evento_d = |(out_d & ~out_q);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      filt_q   <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      evento_q <= 1'b0;
    end else begin
      s1_q     <= {temp_raw, manual_raw, sobrecarga_raw, humo_raw};
      s2_q     <= s1_q;
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      evento_q <= evento_d;
    end
  assign {Temperatura, Manual, SobreCarga, Humo} = out_q;
  assign evento = evento_q;
endmodule
